// File: rtl/iter_shift_unit_pkg.sv
// shifter_pkg: shared types and defaults for the iterative shift unit.
//   shift_op_e    : OP_SLL (zero fill) / OP_SRA (sign fill)
//   shift_state_e : S_IDLE / S_SHIFT / S_DONE
//   STAGES        : number of binary shift stages (16,8,4,2,1 for 32 bits)
package shifter_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SHAMT_W_DEF = $clog2(WIDTH_DEF);
  localparam int unsigned STAGES      = SHAMT_W_DEF;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shift_state_e;

endpackage

// File: rtl/iter_shift_unit_if.sv
// iter_shift_unit_if: request/response handshake bundle of the iterative shifter.
//   master (requester/consumer): drives in_valid, in_op, in_operand, in_shamt, out_ready
//   slave  (shift unit)        : drives in_ready, out_valid, data_result, busy
interface iter_shift_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic               in_op;
  logic [WIDTH-1:0]   in_operand;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_result;
  logic               busy;

  modport master (
    output in_valid, in_op, in_operand, in_shamt, out_ready,
    input  in_ready, out_valid, data_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_operand, in_shamt, out_ready,
    output in_ready, out_valid, data_result, busy
  );
endinterface

// File: rtl/iter_shift_unit_stage_sel.sv
// shift_stage_sel: combinational single-stage shifter. Shifts acc_i by
// 2^(SHAMT_W-1-stage_i) left (OP_SLL, zero fill) or right (OP_SRA, fill_i fill).
//   acc_i    : value to shift
//   stage_i  : stage index, 0 = largest amount
//   op_i     : shift direction/kind
//   fill_i   : bit copied into vacated MSBs for OP_SRA
//   result_o : shifted value
module shift_stage_sel
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STG_W   = 3
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [STG_W-1:0] stage_i,
  input  shift_op_e        op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [SHAMT_W-1:0] TOP_AMT = SHAMT_W'(1 << (SHAMT_W - 1));

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   all_ones;
  logic [WIDTH-1:0]   fill_mask;

  always_comb begin
    amt       = TOP_AMT >> stage_i;
    all_ones  = {WIDTH{1'b1}};
    // Vacated MSB positions after a logical right shift by amt.
    fill_mask = ~(all_ones >> amt);
    if (op_i == OP_SRA) begin
      result_o = (acc_i >> amt) | (fill_i ? fill_mask : '0);
    end else begin
      result_o = acc_i << amt;
    end
  end

endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multicycle SLL/SRA shifter, one binary stage (16,8,4,2,1)
// per clock, result returned over a valid/ready handshake.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : iter_shift_unit_if.slave (in_valid/in_ready/in_op/in_operand/
//             in_shamt, out_valid/out_ready/data_result, busy)
// Build option: define SHIFT_EARLY_DONE_EN to finish after the stage of the
// lowest set shamt bit (shamt=0 goes straight to DONE). Results are identical.
module iter_shift_unit
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic           clock,
  input logic           reset_n,
  iter_shift_unit_if.slave bus
);

  localparam int unsigned STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  shift_op_e          op_q, op_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               sign_q, sign_d;

  logic [SHAMT_W-1:0] shamt_rev;
  logic [WIDTH-1:0]   shifted;

  shift_stage_sel #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STG_W   (STG_W)
  ) u_stage (
    .acc_i    (acc_q),
    .stage_i  (stage_q),
    .op_i     (op_q),
    .fill_i   ((op_q == OP_SRA) && sign_q),
    .result_o (shifted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      stage_q <= '0;
      op_q    <= OP_SLL;
      shamt_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      stage_q <= stage_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    stage_d = stage_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    sign_d  = sign_q;

    // Bit-reversed shamt so stage k tests shamt_rev[k] (stage 0 = MSB).
    shamt_rev = '0;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      shamt_rev[i] = shamt_q[SHAMT_W-1-i];
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_operand;
          op_d    = shift_op_e'(bus.in_op);
          shamt_d = bus.in_shamt;
          sign_d  = bus.in_operand[WIDTH-1];
          stage_d = '0;
          state_d = S_SHIFT;
`ifdef SHIFT_EARLY_DONE_EN
          if (bus.in_shamt == '0) state_d = S_DONE;
`endif
        end
      end
      S_SHIFT: begin
        if (shamt_rev[stage_q]) acc_d = shifted;
        if (stage_q == STG_W'(SHAMT_W - 1)) begin
          state_d = S_DONE;
        end else begin
          stage_d = stage_q + 1'b1;
        end
`ifdef SHIFT_EARLY_DONE_EN
        // No set bits left in later (smaller) stages: nothing more to apply.
        if (((shamt_rev >> stage_q) >> 1) == '0) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.data_result = (state_q == S_DONE) ? acc_q : '0;

endmodule

// File: tb/tb_iter_shift_unit.sv
module tb_iter_shift_unit;

  logic clk;
  logic rst_n;

  iter_shift_unit_if #(.WIDTH(32)) bus_if ();

  iter_shift_unit #(.WIDTH(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [4:0] sh);
`ifdef SHIFT_EARLY_DONE_EN
    // DONE is entered on the accept edge for shamt=0; otherwise after the
    // stage holding the lowest set bit (bit b lives in stage 4-b).
    if (sh == 5'd0) return 0;
    for (int b = 0; b < 5; b++) if (sh[b]) return 5 - b;
    return 5;
`else
    return 5;
`endif
  endfunction

  // Issue one request, wait for the result with out_ready=1, consume it.
  task automatic run_op(input logic op, input logic [31:0] opnd, input logic [4:0] sh,
                        output logic [31:0] res, output int lat);
    int guard = 0;
    while (!bus_if.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus_if.in_valid   = 1'b1;
    bus_if.in_op      = op;
    bus_if.in_operand = opnd;
    bus_if.in_shamt   = sh;
    bus_if.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = bus_if.data_result;
    @(posedge clk); #1;
  endtask

  logic [31:0] res;
  int          lat;
  logic [31:0] q_exp[$];
  logic [31:0] r_opnd[1000];
  logic        r_op[1000];
  logic [4:0]  r_sh[1000];

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{1'b1, 32'h8000_00F0, 5'd4,  32'hF800_000F};
    vecs[2]  = '{1'b1, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[7]  = '{1'b0, 32'h1234_5678, 5'd16, 32'h5678_0000};
    vecs[8]  = '{1'b1, 32'h1234_5678, 5'd8,  32'h0012_3456};
    vecs[9]  = '{1'b1, 32'hF000_0000, 5'd1,  32'hF800_0000};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[11] = '{1'b0, 32'h0000_FFFF, 5'd21, 32'hFFE0_0000};
    vecs[12] = '{1'b1, 32'h8765_4321, 5'd12, 32'hFFF8_7654};
    vecs[13] = '{1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001};

    rst_n             = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_op      = 1'b0;
    bus_if.in_operand = '0;
    bus_if.in_shamt   = '0;
    bus_if.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_busy",      32'(bus_if.busy),      32'd0);
    check("rst_data",      bus_if.data_result,    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].operand, vecs[i].shamt, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].shamt)));
      check($sformatf("vec%0d_released", i), 32'(bus_if.out_valid), 32'd0);
    end

    // Reset in the middle of SHIFT
    bus_if.in_valid   = 1'b1;
    bus_if.in_op      = 1'b0;
    bus_if.in_operand = 32'h0000_0001;
    bus_if.in_shamt   = 5'd5;
    bus_if.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    check("midrst_busy_before", 32'(bus_if.busy), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus_if.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst_data",      bus_if.data_result,    32'd0);
    check("midrst_busy",      32'(bus_if.busy),      32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 32'h0000_0001, 5'd5, res, lat);
    check("postrst_result",  res,      32'h0000_0020);
    check("postrst_latency", 32'(lat), 32'(exp_latency(5'd5)));

    // Consumer stall in DONE, inputs toggled during SHIFT
    bus_if.in_valid   = 1'b1;
    bus_if.in_op      = 1'b1;
    bus_if.in_operand = 32'h8000_00F0;
    bus_if.in_shamt   = 5'd4;
    bus_if.out_ready  = 1'b0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      bus_if.in_operand = ~bus_if.in_operand;
      bus_if.in_op      = ~bus_if.in_op;
      bus_if.in_shamt   = bus_if.in_shamt + 5'd3;
      @(posedge clk); #1; lat++;
    end
    check("stall_latency", 32'(lat), 32'(exp_latency(5'd4)));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_out_valid", i), 32'(bus_if.out_valid), 32'd1);
      check($sformatf("stall%0d_data", i),      bus_if.data_result,    32'hF800_000F);
      check($sformatf("stall%0d_in_ready", i),  32'(bus_if.in_ready),  32'd0);
      bus_if.in_operand = ~bus_if.in_operand;
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("stall_release_in_ready",  32'(bus_if.in_ready),  32'd1);

    // Back-to-back random requests against a golden << / >>> model
    for (int i = 0; i < 1000; i++) begin
      r_opnd[i] = $urandom;
      r_op[i]   = 1'($urandom_range(0, 1));
      r_sh[i]   = 5'($urandom_range(0, 31));
    end
    begin
      int  sent = 0;
      int  done = 0;
      int  cyc  = 0;
      logic prev_ready;
      logic prev_valid;
      logic [31:0] e;
      bus_if.out_ready  = 1'b1;
      bus_if.in_valid   = 1'b1;
      bus_if.in_op      = r_op[0];
      bus_if.in_operand = r_opnd[0];
      bus_if.in_shamt   = r_sh[0];
      prev_ready = bus_if.in_ready;
      prev_valid = bus_if.out_valid;
      while (done < 1000 && cyc < 10000) begin
        @(posedge clk); #1; cyc++;
        if (prev_ready && bus_if.in_valid) begin
          if (r_op[sent]) e = 32'($signed(r_opnd[sent]) >>> r_sh[sent]);
          else            e = r_opnd[sent] << r_sh[sent];
          q_exp.push_back(e);
          sent++;
          if (sent < 1000) begin
            bus_if.in_op      = r_op[sent];
            bus_if.in_operand = r_opnd[sent];
            bus_if.in_shamt   = r_sh[sent];
          end else begin
            bus_if.in_valid = 1'b0;
          end
        end
        if (prev_valid) check($sformatf("b2b%0d_next_accept", done), 32'(bus_if.in_ready), 32'd1);
        if (bus_if.out_valid) begin
          if (q_exp.size() == 0) begin
            check("b2b_spurious_valid", 32'(bus_if.out_valid), 32'd0);
          end else begin
            e = q_exp.pop_front();
            check($sformatf("b2b%0d_result", done), bus_if.data_result, e);
          end
          done++;
        end
        prev_ready = bus_if.in_ready;
        prev_valid = bus_if.out_valid;
      end
      check("b2b_completed", 32'(done), 32'd1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
